// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with load handshake and ready-gated serial stream.
// Optional even-parity trailer bit when PIPO_PARITY_EN is defined.
module piso_serializer #(
    parameter int D_SIZE    = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [D_SIZE-1:0] parallel_in,
    input  logic              serial_ready,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              frame_done,
    output logic              busy
);
    localparam int CW = $clog2(D_SIZE);
    localparam logic [CW-1:0] LAST = CW'(D_SIZE - 1);
    localparam int OUT = MSB_FIRST ? D_SIZE - 1 : 0;

`ifdef PIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t            state, state_n;
    logic [D_SIZE-1:0] sr, sr_n, shifted;
    logic [CW-1:0]     cnt, cnt_n;
    logic              data_last, last, accept, adv;

`ifdef PIPO_PARITY_EN
    logic par;
    always_ff @(posedge clk or posedge rst)
        if (rst) par <= 1'b0;
        else if (accept) par <= ^parallel_in;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
        end

    assign data_last = (state == SHIFT) && (cnt == LAST);
`ifdef PIPO_PARITY_EN
    assign last = (state == PARITY);
`else
    assign last = data_last;
`endif
    assign serial_out   = sr[OUT];
    assign serial_valid = (state != IDLE);
    assign busy         = serial_valid;
    assign frame_done   = last;
    assign load_ready   = (state == IDLE) || (last && serial_ready);
    assign accept       = load_valid && load_ready;
    assign adv          = serial_valid && serial_ready;
    assign shifted      = MSB_FIRST ? {sr[D_SIZE-2:0], 1'b0} : {1'b0, sr[D_SIZE-1:1]};

    // Accept wins over the final advance so back-to-back frames have no bubble.
    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        if (accept) begin
            state_n = SHIFT;
            sr_n    = parallel_in;
            cnt_n   = '0;
        end else if (adv && last) begin
            state_n = IDLE;
            sr_n    = '0;
            cnt_n   = '0;
        end
`ifdef PIPO_PARITY_EN
        else if (adv && data_last) begin
            state_n = PARITY;
            sr_n    = D_SIZE'(par) << OUT;
        end
`endif
        else if (adv) begin
            sr_n  = shifted;
            cnt_n = cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table-driven check of MSB-first and LSB-first instances plus a mid-frame reset sequence.
module tb_piso_serializer;
    logic       clk = 1'b0, rst = 1'b0, load_valid = 1'b0, serial_ready = 1'b1;
    logic [3:0] parallel_in = '0;
    logic       m_lr, m_so, m_sv, m_fd, m_busy;
    logic       l_lr, l_so, l_sv, l_fd, l_busy;
    int         checks = 0, failures = 0;

    typedef struct {
        logic       lv;
        logic [3:0] pin;
        logic       sr;
        logic       m;
        logic       l;
        logic       sv;
        logic       fd;
        logic       lr;
    } vec_t;
    vec_t vecs[$];

    piso_serializer #(.D_SIZE(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(m_lr), .parallel_in(parallel_in),
        .serial_ready(serial_ready), .serial_out(m_so), .serial_valid(m_sv), .frame_done(m_fd), .busy(m_busy));

    piso_serializer #(.D_SIZE(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_lr), .parallel_in(parallel_in),
        .serial_ready(serial_ready), .serial_out(l_so), .serial_valid(l_sv), .frame_done(l_fd), .busy(l_busy));

    always #5 clk = ~clk;

    function automatic void add(input logic lv, input logic [3:0] pin, input logic sr, input logic m,
                                input logic l, input logic sv, input logic fd, input logic lr);
        vecs.push_back('{lv, pin, sr, m, l, sv, fd, lr});
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_so_m"}, m_so, 1'b0);
        chk({tag, "_so_l"}, l_so, 1'b0);
        chk({tag, "_sv_m"}, m_sv, 1'b0);
        chk({tag, "_sv_l"}, l_sv, 1'b0);
        chk({tag, "_fd_m"}, m_fd, 1'b0);
        chk({tag, "_busy_m"}, m_busy, 1'b0);
        chk({tag, "_lr_m"}, m_lr, 1'b1);
        chk({tag, "_lr_l"}, l_lr, 1'b1);
    endtask

    initial begin
        logic [3:0] w;
        int nb;
`ifdef PIPO_PARITY_EN
        // single frame 1011 + parity 1
        add(0, 4'b0000, 1, 0, 0, 0, 0, 1);
        add(1, 4'b1011, 1, 0, 0, 0, 0, 1);
        add(0, 4'b1011, 1, 1, 1, 1, 0, 0);
        add(0, 4'b1011, 1, 0, 1, 1, 0, 0);
        add(0, 4'b1011, 1, 1, 0, 1, 0, 0);
        add(0, 4'b1011, 1, 1, 1, 1, 0, 0);
        add(0, 4'b1011, 1, 1, 1, 1, 1, 1);
        // 0110 + parity 0, then 1011 back-to-back on the parity bit
        add(1, 4'b0110, 1, 0, 0, 0, 0, 1);
        add(0, 4'b0110, 1, 0, 0, 1, 0, 0);
        add(0, 4'b0110, 1, 1, 1, 1, 0, 0);
        add(0, 4'b0110, 1, 1, 1, 1, 0, 0);
        add(0, 4'b0110, 1, 0, 0, 1, 0, 0);
        add(1, 4'b1011, 1, 0, 0, 1, 1, 1);
        add(0, 4'b1011, 1, 1, 1, 1, 0, 0);
        add(0, 4'b1011, 1, 0, 1, 1, 0, 0);
        add(0, 4'b1011, 1, 1, 0, 1, 0, 0);
        add(0, 4'b1011, 1, 1, 1, 1, 0, 0);
        add(0, 4'b1011, 1, 1, 1, 1, 1, 1);
        add(0, 4'b0000, 1, 0, 0, 0, 0, 1);
        nb = 5;
`else
        // single frame 1011
        add(0, 4'b0000, 1, 0, 0, 0, 0, 1);
        add(1, 4'b1011, 1, 0, 0, 0, 0, 1);
        add(0, 4'b1011, 1, 1, 1, 1, 0, 0);
        add(0, 4'b1011, 1, 0, 1, 1, 0, 0);
        add(0, 4'b1011, 1, 1, 0, 1, 0, 0);
        add(0, 4'b1011, 1, 1, 1, 1, 1, 1);
        add(0, 4'b0000, 1, 0, 0, 0, 0, 1);
        // back-to-back 1011 then 0110 with load_valid held
        add(1, 4'b1011, 1, 0, 0, 0, 0, 1);
        add(1, 4'b1011, 1, 1, 1, 1, 0, 0);
        add(1, 4'b1011, 1, 0, 1, 1, 0, 0);
        add(1, 4'b1011, 1, 1, 0, 1, 0, 0);
        add(1, 4'b0110, 1, 1, 1, 1, 1, 1);
        add(0, 4'b0110, 1, 0, 0, 1, 0, 0);
        add(0, 4'b0110, 1, 1, 1, 1, 0, 0);
        add(0, 4'b0110, 1, 1, 1, 1, 0, 0);
        add(0, 4'b0110, 1, 0, 0, 1, 1, 1);
        add(0, 4'b0000, 1, 0, 0, 0, 0, 1);
        // stall for 3 cycles on the 2nd bit
        add(1, 4'b1011, 1, 0, 0, 0, 0, 1);
        add(0, 4'b1011, 1, 1, 1, 1, 0, 0);
        add(0, 4'b1011, 0, 0, 1, 1, 0, 0);
        add(0, 4'b1011, 0, 0, 1, 1, 0, 0);
        add(0, 4'b1011, 0, 0, 1, 1, 0, 0);
        add(0, 4'b1011, 1, 0, 1, 1, 0, 0);
        add(0, 4'b1011, 1, 1, 0, 1, 0, 0);
        add(0, 4'b1011, 1, 1, 1, 1, 1, 1);
        add(0, 4'b0000, 1, 0, 0, 0, 0, 1);
        nb = 4;
`endif
        #2 rst = 1'b1;
        #1 chk_idle("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            load_valid   = vecs[i].lv;
            parallel_in  = vecs[i].pin;
            serial_ready = vecs[i].sr;
            #1;
            chk($sformatf("v%0d_so_m", i), m_so, vecs[i].m);
            chk($sformatf("v%0d_so_l", i), l_so, vecs[i].l);
            chk($sformatf("v%0d_sv", i), m_sv, vecs[i].sv);
            chk($sformatf("v%0d_busy", i), m_busy, vecs[i].sv);
            chk($sformatf("v%0d_fd", i), m_fd, vecs[i].fd);
            chk($sformatf("v%0d_lr", i), m_lr, vecs[i].lr);
            chk($sformatf("v%0d_lr_l", i), l_lr, vecs[i].lr);
        end

        // reset in the middle of a 1111 frame, then a clean 0001 frame
        @(negedge clk);
        load_valid = 1'b1; parallel_in = 4'b1111; serial_ready = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        #1 chk("abort_b0", m_so, 1'b1);
        @(negedge clk);
        #1 chk("abort_b1", m_so, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_idle("midrst");
        @(negedge clk);
        rst = 1'b0;
        w = 4'b0001;
        load_valid = 1'b1; parallel_in = w;
        #1 chk_idle("postrst");
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            #1;
            chk($sformatf("clean%0d_so_m", k), m_so, k < 4 ? w[3-k] : ^w);
            chk($sformatf("clean%0d_so_l", k), l_so, k < 4 ? w[k] : ^w);
            chk($sformatf("clean%0d_sv", k), m_sv, 1'b1);
            chk($sformatf("clean%0d_fd", k), m_fd, k == nb - 1);
        end
        @(negedge clk);
        #1 chk_idle("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out shift register with a valid/ready load handshake and a ready-gated serial output stream.
- Complement of the team's SIPO shift register: a word loaded here and shifted into a SIPO of the same D_SIZE and bit order reappears unchanged on its parallel output.
- Sits on the transmit side of simple bit-serial links between blocks.

Parameters:
- D_SIZE, 4, data word width in bits (must be >= 2).
- MSB_FIRST, 1, bit order: 1 = bit D_SIZE-1 sent first, 0 = bit 0 sent first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  parallel_in holds a word to send.
- load_ready  output  1  block can accept a word this cycle.
- parallel_in  input  D_SIZE  word to serialize.
- serial_ready  input  1  downstream consumes serial_out this cycle.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out holds a valid bit.
- frame_done  output  1  high while the last bit of a frame is presented.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset is asynchronous and active-high, and clears everything. States: IDLE, SHIFT, and PARITY (PARITY only with PARITY_EN).
- Reset values: state IDLE, shift register 0, bit counter 0, serial_out 0, serial_valid 0, frame_done 0, busy 0, load_ready 1.
- Accept: a word is accepted on a rising edge where load_valid && load_ready. At that edge:
  - parallel_in is captured into the shift register;
  - the bit counter is set to 0;
  - state goes to SHIFT.
- Latency: the first bit appears on serial_out in the cycle after the accept edge.
- serial_out source: taken directly from a register bit, never from a combinational mux of inputs.
  - MSB_FIRST=1: shift_reg[D_SIZE-1], shifting toward the MSB.
  - MSB_FIRST=0: shift_reg[0], shifting toward the LSB.
- serial_valid and busy are 1 in SHIFT and PARITY, 0 in IDLE.
- Advance: a bit is consumed on an edge where serial_valid && serial_ready. On that edge the register shifts by one, zero-filling the vacated end, and the counter increments.
- Stall: while serial_ready=0, serial_out, the counter and the state all hold.
- Last bit: counter == D_SIZE-1 in SHIFT, or any cycle in PARITY.
  - frame_done=1 while the last bit is presented, whether or not it is being consumed.
- load_ready = (state==IDLE) || (last bit && serial_ready). This allows back-to-back frames with no idle bubble. It is the only combinational input-to-output path.
- Last bit consumed:
  - if load_valid is also high, the new word is loaded and state stays in SHIFT;
  - otherwise state goes to IDLE and serial_out goes to 0.
- load_valid while busy and not at the last consumed bit: ignored, no capture. The upstream must hold parallel_in until load_ready.
- Counter width: clog2(D_SIZE) bits, sized locally.
- Reset mid-frame: the frame is dropped immediately and the outputs take their reset values. No partial completion and no frame_done pulse.

Optional Feature:
- Macro: PIPO_PARITY_EN.
- Defined:
  - even parity of the D_SIZE data bits is computed and stored at accept;
  - after the last data bit is consumed, state goes to PARITY and the parity bit is presented as one extra serial bit;
  - frame_done and the load_ready look-ahead move from the last data bit to the parity bit;
  - frame length is D_SIZE+1 bits.
- Undefined: the PARITY state and parity register do not exist; frames are D_SIZE bits.

Test Plan (D_SIZE=4, serial_ready=1 unless stated):
- MSB_FIRST=1: load 4'b1011 -> serial_out 1,0,1,1 on the 4 cycles after accept, frame_done on the 4th, then serial_valid=0 and load_ready=1.
- MSB_FIRST=0: load 4'b1011 -> serial_out 1,1,0,1.
- Back-to-back: load_valid held with 4'b1011 then 4'b0110 -> 8 consecutive serial_valid cycles carrying 1,0,1,1,0,1,1,0, with load_ready=1 only on cycle 4.
- Stall: serial_ready=0 for 3 cycles while the 2nd bit is presented -> serial_out holds 0 for those cycles, the sequence resumes unchanged, and frame_done is delayed by 3 cycles.
- Reset mid-frame: rst pulse after 2 bits -> all outputs return to reset values immediately; the next load of 4'b0001 sends 0,0,0,1 with no residue.
- PIPO_PARITY_EN defined: load 4'b1011 -> 1,0,1,1,1 (parity 1); load 4'b0110 -> 0,1,1,0,0. frame_done is on the 5th bit.
